mem_subsystem: RTL and testbench
================================

// Module: mem_subsystem
// PURPOSE
//  Two-level memory subsystem: a direct-mapped, write-through cache in front of a
//  fixed-latency word-addressed main memory. A LOAD/STORE requester sits on one
//  side. Cache hits answer in 1 cycle after acceptance; misses pay MEM_LATENCY
//  cycles and fill the line. One request is in flight at a time.
// PARAMETERS
//  MEM_WORDS    256  main-memory depth in 32-bit words (power of 2)
//  CACHE_LINES  8    cache lines, 1 word per line (power of 2)
//  MEM_LATENCY  10   main-memory access cycles (>=1)
// PORTS
//  CLK            in   1   clock, all logic on rising edge
//  RST_N          in   1   reset, synchronous, active-low
//  input_address  in   32  word address; only [log2(MEM_WORDS)-1:0] used, rest ignored
//  LOAD           in   1   load request level
//  STORE          in   1   store request level
//  store_data     in   32  write data, sampled with the STORE request
//  data           out  32  registered load result
//  READY          out  1   one-cycle pulse: request completed
//  hit_count      out  16  loads that hit (saturating)
//  miss_count     out  16  loads that missed (saturating)
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): state IDLE, all valid bits 0, data=0, READY=0,
//    counters 0, wait counter 0. Main-memory array NOT reset. Reset mid-request
//    aborts it; an uncommitted store is discarded.
//  - Main memory is initialised at time zero to mem[i] = 32'hA000_0000 | i.
//  - Address split: index = addr[log2(CACHE_LINES)-1:0]; tag = remaining used bits.
//  - States: IDLE, LOOKUP, MISS_WAIT, STORE_WAIT.
//  - IDLE: at edge k, if LOAD=1 latch address -> LOOKUP. Else if STORE=1 latch
//    address and store_data -> STORE_WAIT, counter=MEM_LATENCY-1. LOAD wins if both.
//  - LOOKUP (edge k+1): hit (valid & tag match) -> data<=line, READY<=1, hit_count++,
//    -> IDLE. Miss -> MISS_WAIT, counter=MEM_LATENCY-1, miss_count++.
//  - MISS_WAIT: decrement each edge; on the edge with counter==0: line<=mem word,
//    valid=1, tag set, data<=mem word, READY<=1 -> IDLE. Load data visible after
//    edge k+1+MEM_LATENCY.
//  - STORE_WAIT: on the edge with counter==0: mem[addr]<=store_data; if line hit,
//    update line word too (no write-allocate on miss); READY<=1 -> IDLE.
//  - data changes only on load completion; holds between loads; stores never change it.
//  - READY is high exactly one cycle per completed request, else 0.
//  - LOAD/STORE ignored outside IDLE. A request still high in IDLE after completion
//    starts a new request (requester must drop it on READY/data change).
//  - Index aliasing: a different tag at the same index replaces the line on fill.
//  - Counters saturate at 16'hFFFF.
// TESTING
//  1 Reset, then LOAD addr 0x04 -> miss; data=A0000004 after 1+MEM_LATENCY edges,
//    READY 1 cycle, miss_count=1.
//  2 Then LOAD addr 0x19 -> miss, data=A0000019; 0x04 line untouched (index 1 vs 4).
//  3 LOAD addr 0x04 again -> hit, data=A0000004 one edge after acceptance, hit_count=1.
//  4 STORE 0x04, store_data=DEADBEEF -> READY after MEM_LATENCY edges, data unchanged;
//    LOAD 0x04 -> hit, DEADBEEF.
//  5 LOAD 0x0C (aliases 0x04) -> miss, A000000C; LOAD 0x04 -> miss, DEADBEEF.
//  6 Assert RST_N=0 during MISS_WAIT -> data=0, READY=0, IDLE; LOAD 0x0C misses again.

Source files
------------

// File: rtl/mem_subsystem.sv
// Direct-mapped, write-through, one-word-per-line cache in front of a fixed-latency
// word-addressed main memory; one LOAD/STORE request in flight at a time.
module mem_subsystem #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned CACHE_LINES = 8,
  parameter int unsigned MEM_LATENCY = 10
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] input_address,
  input  logic        LOAD,
  input  logic        STORE,
  input  logic [31:0] store_data,
  output logic [31:0] data,
  output logic        READY,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned IW = $clog2(CACHE_LINES);
  localparam int unsigned TW = AW - IW;
  localparam int unsigned CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_WAIT, STORE_WAIT} state_t;

  state_t            state_q;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [CW-1:0]     cnt_q;
  logic [CACHE_LINES-1:0] valid_q;
  logic [TW-1:0]     tag_q  [CACHE_LINES];
  logic [31:0]       line_q [CACHE_LINES];
  logic [31:0]       data_q;
  logic              ready_q;
  logic [15:0]       hit_q;
  logic [15:0]       miss_q;

  // Memory holds contents XORed with the power-up pattern A000_0000|i, so a
  // uniform all-zero initial value yields the required per-word start contents.
  logic [31:0]       mem_q [MEM_WORDS] = '{default: '0};

  logic [IW-1:0]     idx;
  logic [TW-1:0]     tg;
  logic              line_hit;
  logic [31:0]       mem_rd;
  logic              unused_addr;

  function automatic logic [31:0] init_pat(input logic [AW-1:0] a);
    return 32'hA000_0000 | 32'(a);
  endfunction

  assign idx         = addr_q[IW-1:0];
  assign tg          = addr_q[AW-1:IW];
  assign line_hit    = valid_q[idx] && (tag_q[idx] == tg);
  assign mem_rd      = mem_q[addr_q] ^ init_pat(addr_q);
  assign unused_addr = ^input_address[31:AW];

  always_ff @(posedge CLK) begin
    if (RST_N && state_q == STORE_WAIT && cnt_q == '0)
      mem_q[addr_q] <= wdata_q ^ init_pat(addr_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      valid_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (LOAD) begin
            addr_q  <= input_address[AW-1:0];
            state_q <= LOOKUP;
          end else if (STORE) begin
            addr_q  <= input_address[AW-1:0];
            wdata_q <= store_data;
            cnt_q   <= CW'(MEM_LATENCY - 1);
            state_q <= STORE_WAIT;
          end
        end
        LOOKUP: begin
          if (line_hit) begin
            data_q  <= line_q[idx];
            ready_q <= 1'b1;
            if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            state_q <= IDLE;
          end else begin
            cnt_q   <= CW'(MEM_LATENCY - 1);
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
            state_q <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (cnt_q == '0) begin
            line_q[idx]  <= mem_rd;
            tag_q[idx]   <= tg;
            valid_q[idx] <= 1'b1;
            data_q       <= mem_rd;
            ready_q      <= 1'b1;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STORE_WAIT: begin
          if (cnt_q == '0) begin
            if (line_hit) line_q[idx] <= wdata_q;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign READY      = ready_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_mem_subsystem.sv
// Randomized bench for mem_subsystem against a behavioural memory/cache model.
module tb_mem_subsystem;

  localparam int unsigned L = 10;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] input_address;
  logic        LOAD;
  logic        STORE;
  logic [31:0] store_data;
  logic [31:0] data;
  logic        READY;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: memory contents, which word each cache slot currently holds, counters.
  logic [31:0] mem_m [256];
  bit          vld_m [8];
  int unsigned slot_addr_m [8];
  int unsigned hits_m, misses_m;
  logic [31:0] data_m;

  mem_subsystem #(.MEM_WORDS(256), .CACHE_LINES(8), .MEM_LATENCY(L)) dut (
    .CLK(CLK), .RST_N(RST_N), .input_address(input_address), .LOAD(LOAD),
    .STORE(STORE), .store_data(store_data), .data(data), .READY(READY),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) vld_m[i] = 0;
    hits_m = 0; misses_m = 0; data_m = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_data"}, data, data_m);
    chk({tag, "_hits"}, 32'(hit_count), 32'(hits_m));
    chk({tag, "_miss"}, 32'(miss_count), 32'(misses_m));
  endtask

  task automatic do_req(input bit ld, input bit st, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int unsigned n, a, slot, exp_lat;
    bit got, hit;
    a    = addr % 256;
    slot = a % 8;
    @(negedge CLK);
    LOAD = ld; STORE = st; input_address = addr; store_data = wdata;
    @(posedge CLK); #1;
    chk("accept_ready", 32'(READY), 32'd0);
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (READY) got = 1;
    end
    LOAD = 0; STORE = 0;
    chk("completed", 32'(got), 32'd1);
    if (ld) begin
      hit = vld_m[slot] && slot_addr_m[slot] == a;
      exp_lat = hit ? 1 : 1 + L;
      if (hit) hits_m++; else misses_m++;
      vld_m[slot] = 1; slot_addr_m[slot] = a;
      data_m = mem_m[a];
    end else begin
      exp_lat = L;
      mem_m[a] = wdata;
    end
    chk(ld ? "load_latency" : "store_latency", n, exp_lat);
    check_state("after_req");
    @(posedge CLK); #1;
    chk("ready_one_cycle", 32'(READY), 32'd0);
  endtask

  task automatic reset_mid(input bit ld, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge CLK);
    LOAD = ld; STORE = !ld; input_address = addr; store_data = wdata;
    @(posedge CLK);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 0; LOAD = 0; STORE = 0;
    @(posedge CLK); #1;
    model_reset();
    chk("rst_ready", 32'(READY), 32'd0);
    check_state("rst");
    @(negedge CLK);
    RST_N = 1;
  endtask

  initial begin
    logic [31:0] a, w;
    int unsigned pool [16];
    for (int i = 0; i < 256; i++) mem_m[i] = 32'hA000_0000 | 32'(i);
    model_reset();
    RST_N = 0; LOAD = 0; STORE = 0; input_address = '0; store_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ready", 32'(READY), 32'd0);
    check_state("reset");
    @(negedge CLK);
    RST_N = 1;

    do_req(1, 0, 32'h04, '0);
    chk("t1_data", data, 32'hA000_0004);
    chk("t1_miss", 32'(miss_count), 32'd1);
    do_req(1, 0, 32'h19, '0);
    chk("t2_data", data, 32'hA000_0019);
    do_req(1, 0, 32'h04, '0);
    chk("t3_data", data, 32'hA000_0004);
    chk("t3_hits", 32'(hit_count), 32'd1);
    do_req(0, 1, 32'h04, 32'hDEADBEEF);
    chk("t4_store_hold", data, 32'hA000_0004);
    do_req(1, 0, 32'h04, '0);
    chk("t4_data", data, 32'hDEADBEEF);
    do_req(1, 0, 32'h0C, '0);
    chk("t5_alias", data, 32'hA000_000C);
    do_req(1, 0, 32'h04, '0);
    chk("t5_refill", data, 32'hDEADBEEF);
    do_req(1, 0, 32'hFFFF_FF04, '0);
    chk("upper_bits_ignored", data, 32'hDEADBEEF);
    do_req(1, 1, 32'h19, 32'h1234_5678);
    chk("load_wins", data, 32'hA000_0019);

    reset_mid(1, 32'h0C, '0);
    do_req(1, 0, 32'h0C, '0);
    chk("t6_miss_after_rst", 32'(miss_count), 32'd1);
    reset_mid(0, 32'h0C, 32'h5555_AAAA);
    do_req(1, 0, 32'h0C, '0);
    chk("aborted_store", data, 32'hA000_000C);

    for (int i = 0; i < 16; i++) pool[i] = $urandom_range(0, 255);
    for (int k = 0; k < 200; k++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'(pool[$urandom_range(0, 15)]) : 32'($urandom_range(0, 255));
      a = a | ({$urandom} & 32'hFFFF_FF00);
      w = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: do_req(0, 1, a, w);
        3:       do_req(1, 1, a, w);
        default: do_req(1, 0, a, w);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
